// File: rtl/aes_mc_pkg.sv
// Shared AES MixColumns definitions: reduction constant, FSM encoding, xtime.
package aes_mc_pkg;

  localparam logic [7:0] AES_POLY = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_mc_col.sv
// Combinational MixColumns for a single 32-bit column (row r at bits [8r+7:8r]).
module aes_mc_col
  import aes_mc_pkg::*;
(
  input  logic [31:0] i_col,
  output logic [31:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[7:0];
  assign w_a1 = i_col[15:8];
  assign w_a2 = i_col[23:16];
  assign w_a3 = i_col[31:24];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // 3a is written as xtime(a)^a inline
  assign o_col[7:0]   = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[31:24] = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_mc_colseq.sv
// Column-serial masked AES MixColumns: one column per cycle, result valid 5 cycles after accept
// (1 with bypass); holds result until out_ready, accepts nothing new until DONE is acknowledged.
module aes_mc_colseq
  import aes_mc_pkg::*;
#(
  parameter int D         = 2,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bypass,
  input  logic [128*D-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*D-1:0] out_data,
  output logic             busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_col;
  logic [128*D-1:0]   r_data;
  logic [128*D-1:0]   w_data_mc;
  logic               w_byp;

  assign w_byp = in_bypass & BYPASS_EN;

  // Every share is transformed independently; only column r_col changes per cycle.
  for (genvar s = 0; s < D; s++) begin : g_share
    logic [127:0] w_sh;
    logic [127:0] w_nxt;
    logic [31:0]  w_cin;
    logic [31:0]  w_cout;

    assign w_sh = r_data[128*s +: 128];

    always_comb begin
      w_cin = w_sh[31:0];
      case (r_col)
        2'd0: w_cin = w_sh[31:0];
        2'd1: w_cin = w_sh[63:32];
        2'd2: w_cin = w_sh[95:64];
        2'd3: w_cin = w_sh[127:96];
        default: w_cin = w_sh[31:0];
      endcase
    end

    aes_mc_col u_col (
      .i_col (w_cin),
      .o_col (w_cout)
    );

    always_comb begin
      w_nxt = w_sh;
      case (r_col)
        2'd0: w_nxt[31:0]   = w_cout;
        2'd1: w_nxt[63:32]  = w_cout;
        2'd2: w_nxt[95:64]  = w_cout;
        2'd3: w_nxt[127:96] = w_cout;
        default: w_nxt = w_sh;
      endcase
    end

    assign w_data_mc[128*s +: 128] = w_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_byp ? DONE : BUSY;
      BUSY:    if (r_col == 2'd3) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == BUSY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col  <= 2'd0;
      r_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_col  <= 2'd0;
          end
        end
        BUSY: begin
          r_data <= w_data_mc;
          r_col  <= r_col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_data;

endmodule

// File: tb/tb_aes_mc_colseq.sv
// Self-checking bench for aes_mc_colseq (D=2) against a GF(2^8) matrix reference model.
module tb_aes_mc_colseq;

  localparam int D = 2;
  localparam int W = 128 * D;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_bypass;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;

  aes_mc_colseq #(.D(D), .BYPASS_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bypass (in_bypass),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply, shift-and-add with AES reduction.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return p;
  endfunction

  // Circulant matrix product: row r, input byte k uses coefficient rowc[(k-r) mod 4].
  function automatic logic [31:0] mc_col_ref(input logic [31:0] a);
    logic [7:0]  rowc [4];
    logic [31:0] b;
    rowc = '{8'h02, 8'h03, 8'h01, 8'h01};
    b = 32'h0;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        b[8*r +: 8] = b[8*r +: 8] ^ gmul(rowc[(k - r + 4) % 4], a[8*k +: 8]);
    return b;
  endfunction

  function automatic logic [127:0] mc128(input logic [127:0] st);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[32*c +: 32] = mc_col_ref(st[32*c +: 32]);
    return o;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] st, input logic byp);
    logic [W-1:0] o;
    for (int s = 0; s < D; s++) o[128*s +: 128] = byp ? st[128*s +: 128] : mc128(st[128*s +: 128]);
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One full transaction; all observations happen at the falling edge.
  task automatic txn(input string tag, input logic [W-1:0] din, input logic byp,
                     input int stall, input logic rnd_ready, input logic intrude);
    logic [W-1:0] exp;
    int n;
    int lat;
    exp       = model(din, byp);
    in_valid  = 1'b1;
    in_data   = din;
    in_bypass = byp;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    chk({tag, "_accept_timeout"}, W'(n < 50), W'(1));
    tick();
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_latency"}, W'(lat), W'(byp ? 1 : 5));
    chk({tag, "_in_ready_low"}, W'(in_ready), W'(0));
    for (int i = 0; i < stall; i++) begin
      if (intrude) begin
        in_valid = 1'b1;
        in_data  = ~din;
      end
      tick();
      chk({tag, "_stall_hold"}, {out_data[W-1:2], out_valid, in_ready},
          {exp[W-1:2], 1'b1, 1'b0});
      chk({tag, "_stall_low2"}, W'(out_data[1:0]), W'(exp[1:0]));
    end
    in_valid = 1'b0;
    if (rnd_ready) begin
      n = 0;
      out_ready = 1'($urandom_range(0, 1));
      while (!out_ready && n < 50) begin
        tick();
        n++;
        out_ready = 1'($urandom_range(0, 1));
      end
      out_ready = 1'b1;
    end else begin
      out_ready = 1'b1;
    end
    chk({tag, "_out_valid"}, W'(out_valid), W'(1));
    chk({tag, "_data"}, out_data, exp);
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_after"}, W'({in_ready, out_valid, busy}), W'(3'b100));
    chk({tag, "_data_held"}, out_data, exp);
  endtask

  logic [127:0] fips_in;
  logic [127:0] fips_exp;
  logic [127:0] r_mask;
  logic [W-1:0] st;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bypass = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    chk("reset_data", out_data, '0);
    rst_n = 1'b1;
    tick();
    chk("idle_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));

    // FIPS-197 columns in share 0, share 1 all-zero must stay zero.
    fips_in  = {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db};
    fips_exp = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    txn("fips", {128'h0, fips_in}, 1'b0, 0, 1'b0, 1'b0);
    chk("fips_const", out_data, {128'h0, fips_exp});

    // Two-share masking of the same state.
    r_mask = rnd128();
    txn("mask", {r_mask ^ fips_in, r_mask}, 1'b0, 0, 1'b0, 1'b0);
    chk("mask_xor", W'(out_data[127:0] ^ out_data[255:128]), W'(fips_exp));
    chk("mask_share0", W'(out_data[127:0]), W'(mc128(r_mask)));

    // Bypass: identical data one cycle after accept.
    txn("bypass", {rnd128(), 128'h00112233445566778899aabbccddeeff}, 1'b1, 0, 1'b0, 1'b0);

    // Backpressure for 10 cycles with an intruding in_valid.
    txn("stall", {rnd128(), rnd128()}, 1'b0, 10, 1'b0, 1'b1);

    // Reset during the third BUSY cycle.
    in_valid = 1'b1;
    in_data  = {rnd128(), rnd128()};
    chk("rst_pre_ready", W'(in_ready), W'(1));
    tick();
    in_valid = 1'b0;
    chk("rst_busy", W'(busy), W'(1));
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    chk("rst_mid_data", out_data, '0);
    txn("post_rst", {rnd128(), rnd128()}, 1'b0, 0, 1'b0, 1'b0);

    // Stream of random states with random downstream readiness.
    for (int i = 0; i < 100; i++) begin
      st = {rnd128(), rnd128()};
      if ($urandom_range(0, 7) == 0) st[255:128] = '0;
      txn("stream", st, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
